// File: rtl/ad9500_pkg.sv
// Shared state encoding and default timing for the AD9500 delay-chip controller.
package ad9500_pkg;

    localparam int DELAY_W       = 8;
    localparam int LE_CYC_DEF    = 2;
    localparam int SETUP_CYC_DEF = 2;
    localparam int TRIG_CYC_DEF  = 2;
    localparam int RST_CYC_DEF   = 2;
    localparam int TMO_CYC_DEF   = 64;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_SETUP     = 3'd2,
        ST_TRIG      = 3'd3,
        ST_WAIT_Q    = 3'd4,
        ST_RST       = 3'd5,
        ST_WAIT_QLOW = 3'd6
    } state_t;

endpackage

// File: rtl/ad9500_sync2.sv
// Two-flop synchroniser for a single asynchronous input, synchronous active-high reset.
module ad9500_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ad9500_ctrl.sv
// AD9500 controller: loads the delay code, fires the trigger, times Q, resets the chip.
// Define AD9500_CTRL_MEAS_EN to keep the trigger-to-Q latency counter and LATENCY output.
//
// state        | meaning
// IDLE         | waiting for LOAD / FIRE
// LATCH        | one cycle of D setup, then LE_OUT high for LE_CYC cycles
// SETUP        | D stable for SETUP_CYC cycles before the trigger
// TRIG         | TRIG_OUT high for TRIG_CYC cycles
// WAIT_Q       | waiting for synchronised Q to rise, or timeout
// RST          | RESET_OUT high for RST_CYC cycles
// WAIT_QLOW    | waiting for synchronised Q to fall, or timeout
module ad9500_ctrl
    import ad9500_pkg::*;
#(
    parameter int LE_CYC    = LE_CYC_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int TRIG_CYC  = TRIG_CYC_DEF,
    parameter int RST_CYC   = RST_CYC_DEF,
    parameter int TMO_CYC   = TMO_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [DELAY_W-1:0] DELAY_IN,
    input  logic               LOAD,
    input  logic               FIRE,
    input  logic               Q_IN,
    output logic [DELAY_W-1:0] D_OUT,
    output logic               LE_OUT,
    output logic               TRIG_OUT,
    output logic               RESET_OUT,
    output logic               BUSY,
    output logic               DONE,
    output logic               TIMEOUT,
    output logic               REJECT,
    output logic [CNT_W-1:0]   LATENCY
);

    if (LE_CYC < 0 || LE_CYC >= 2**CNT_W ||
        SETUP_CYC < 1 || SETUP_CYC >= 2**CNT_W ||
        TRIG_CYC < 1 || TRIG_CYC >= 2**CNT_W ||
        RST_CYC < 1 || RST_CYC >= 2**CNT_W ||
        TMO_CYC <= TRIG_CYC || TMO_CYC >= 2**CNT_W) begin : g_bad_params
        $error("ad9500_ctrl: timing parameters out of range for CNT_W");
    end

    state_t           state;
    logic [CNT_W-1:0] tmr;
    logic             fire_pend;
    logic             q_s;
    logic             q_d;
    logic             q_seen;
    logic             q_rise;
    logic             q_hit;
    logic             trig_start;
    logic             timing;
    logic             wait_expired;

    ad9500_sync2 u_sync_q (
        .clk   (CLK),
        .reset (RESET),
        .d     (Q_IN),
        .q     (q_s)
    );

    assign q_rise     = q_s & ~q_d;
    assign q_hit      = (state == ST_WAIT_Q) && (q_seen || q_rise);
    assign trig_start = (state == ST_SETUP) && (tmr == '0);
    assign timing     = (state == ST_TRIG) || (state == ST_WAIT_Q);

`ifdef AD9500_CTRL_MEAS_EN
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_hold;
    logic [CNT_W-1:0] lat_q;

    // A Q rise seen during TRIG is remembered so DONE can report it once TRIG ends.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lat_cnt  <= '0;
            lat_hold <= '0;
            lat_q    <= '0;
        end else begin
            if (trig_start)
                lat_cnt <= '0;
            else if (timing && lat_cnt != '1)
                lat_cnt <= lat_cnt + CNT_W'(1);
            if (state == ST_TRIG && q_rise && !q_seen)
                lat_hold <= lat_cnt;
            if (q_hit)
                lat_q <= q_seen ? lat_hold : lat_cnt;
        end
    end

    assign wait_expired = (lat_cnt >= CNT_W'(TMO_CYC));
    assign LATENCY      = lat_q;
`else
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            tmo_cnt <= '0;
        else if (trig_start)
            tmo_cnt <= CNT_W'(TMO_CYC);
        else if (timing && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - CNT_W'(1);
    end

    assign wait_expired = (tmo_cnt == '0);
    assign LATENCY      = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            fire_pend <= 1'b0;
            q_d       <= 1'b0;
            q_seen    <= 1'b0;
            D_OUT     <= '0;
            LE_OUT    <= 1'b0;
            TRIG_OUT  <= 1'b0;
            RESET_OUT <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
            REJECT    <= 1'b0;
        end else begin
            q_d     <= q_s;
            DONE    <= 1'b0;
            TIMEOUT <= 1'b0;
            REJECT  <= 1'b0;
            if (state != ST_IDLE && (LOAD || FIRE))
                REJECT <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (LOAD) begin
                        D_OUT     <= DELAY_IN;
                        fire_pend <= FIRE;
                        tmr       <= CNT_W'(LE_CYC);
                        BUSY      <= 1'b1;
                        state     <= ST_LATCH;
                    end else if (FIRE) begin
                        BUSY <= 1'b1;
                        // Q already high: the chip is in an unknown state, clear it instead.
                        if (q_s) begin
                            REJECT    <= 1'b1;
                            RESET_OUT <= 1'b1;
                            tmr       <= CNT_W'(RST_CYC - 1);
                            state     <= ST_RST;
                        end else begin
                            tmr   <= CNT_W'(SETUP_CYC - 1);
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tmr == '0) begin
                        LE_OUT    <= 1'b0;
                        fire_pend <= 1'b0;
                        if (fire_pend) begin
                            tmr   <= CNT_W'(SETUP_CYC - 1);
                            state <= ST_SETUP;
                        end else begin
                            BUSY  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        LE_OUT <= 1'b1;
                        tmr    <= tmr - CNT_W'(1);
                    end
                end
                ST_SETUP: begin
                    if (tmr == '0) begin
                        TRIG_OUT <= 1'b1;
                        q_seen   <= 1'b0;
                        tmr      <= CNT_W'(TRIG_CYC - 1);
                        state    <= ST_TRIG;
                    end else begin
                        tmr <= tmr - CNT_W'(1);
                    end
                end
                ST_TRIG: begin
                    if (q_rise)
                        q_seen <= 1'b1;
                    if (tmr == '0) begin
                        TRIG_OUT <= 1'b0;
                        state    <= ST_WAIT_Q;
                    end else begin
                        tmr <= tmr - CNT_W'(1);
                    end
                end
                ST_WAIT_Q: begin
                    if (q_hit || wait_expired) begin
                        DONE      <= q_hit;
                        TIMEOUT   <= !q_hit;
                        q_seen    <= 1'b0;
                        RESET_OUT <= 1'b1;
                        tmr       <= CNT_W'(RST_CYC - 1);
                        state     <= ST_RST;
                    end
                end
                ST_RST: begin
                    if (tmr == '0) begin
                        RESET_OUT <= 1'b0;
                        tmr       <= CNT_W'(TMO_CYC - 1);
                        state     <= ST_WAIT_QLOW;
                    end else begin
                        tmr <= tmr - CNT_W'(1);
                    end
                end
                ST_WAIT_QLOW: begin
                    if (!q_s) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (tmr == '0) begin
                        TIMEOUT <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        tmr <= tmr - CNT_W'(1);
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9500_ctrl.sv
// Randomised self-checking bench for ad9500_ctrl with a cycle-counting chip model.
module tb_ad9500_ctrl;
    import ad9500_pkg::*;

    localparam int LE_C    = LE_CYC_DEF;
    localparam int SETUP_C = SETUP_CYC_DEF;
    localparam int TRIG_C  = TRIG_CYC_DEF;
    localparam int RST_C   = RST_CYC_DEF;
    localparam int TMO_C   = TMO_CYC_DEF;
    localparam int CW      = CNT_W_DEF;

    logic          CLK = 1'b0;
    logic          RESET, LOAD, FIRE, Q_IN;
    logic [7:0]    DELAY_IN, D_OUT;
    logic          LE_OUT, TRIG_OUT, RESET_OUT, BUSY, DONE, TIMEOUT, REJECT;
    logic [CW-1:0] LATENCY;

    ad9500_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DELAY_IN  (DELAY_IN),
        .LOAD      (LOAD),
        .FIRE      (FIRE),
        .Q_IN      (Q_IN),
        .D_OUT     (D_OUT),
        .LE_OUT    (LE_OUT),
        .TRIG_OUT  (TRIG_OUT),
        .RESET_OUT (RESET_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .TIMEOUT   (TIMEOUT),
        .REJECT    (REJECT),
        .LATENCY   (LATENCY)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the chip-facing code and latency register should hold.
    logic [7:0]    exp_d;
    logic [CW-1:0] exp_lat;

    // Per-sequence observations, index 0 is the cycle after the strobe edge.
    int         hang, busy_n, le_n, le_first, trig_n, trig_first;
    int         done_n, done_i, tmo_n, tmo_i, rej_n, rej_i, rst_n;
    logic       d_bad;
    logic [7:0] d_first;

    task automatic run_seq(input logic ld, input logic fr, input logic [7:0] code,
                           input int q_at, input int inj_i, input logic inj_ld,
                           input logic q_stuck);
        busy_n = 0; le_n = 0; le_first = -1; trig_n = 0; trig_first = -1;
        done_n = 0; done_i = -1; tmo_n = 0; tmo_i = -1; rej_n = 0; rej_i = -1;
        rst_n = 0; d_bad = 1'b0; hang = 1;
        @(posedge CLK); #1;
        DELAY_IN = code; LOAD = ld; FIRE = fr;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK); #1;
            LOAD = 1'b0; FIRE = 1'b0;
            if (i == 0) d_first = D_OUT;
            if (BUSY) busy_n++;
            if (LE_OUT) begin le_n++; if (le_first < 0) le_first = i; end
            if (TRIG_OUT) begin
                trig_n++;
                if (trig_first < 0) trig_first = i;
                if (D_OUT !== code) d_bad = 1'b1;
            end
            if (DONE) begin done_n++; done_i = i; end
            if (TIMEOUT) begin tmo_n++; tmo_i = i; end
            if (REJECT) begin rej_n++; rej_i = i; end
            // The chip clears Q while its reset is held.
            if (RESET_OUT) begin rst_n++; if (!q_stuck) Q_IN = 1'b0; end
            if (i == q_at) Q_IN = 1'b1;
            if (i == inj_i) begin
                if (inj_ld) begin LOAD = 1'b1; DELAY_IN = ~code; end
                else FIRE = 1'b1;
            end
            if (!BUSY) begin hang = 0; break; end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; LOAD = 1'b0; FIRE = 1'b0; Q_IN = 1'b0; DELAY_IN = 8'($urandom);
        repeat (3) @(posedge CLK);
        #1;
        n_vec++; if (D_OUT !== 8'h00) begin n_err++; $display("FAIL reset_d_out got=%h exp=00", D_OUT); end
        n_vec++;
        if ({LE_OUT, TRIG_OUT, RESET_OUT, BUSY} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=0000", {LE_OUT, TRIG_OUT, RESET_OUT, BUSY});
        end
        n_vec++;
        if ({DONE, TIMEOUT, REJECT} !== 3'b0) begin
            n_err++; $display("FAIL reset_pulses got=%b exp=000", {DONE, TIMEOUT, REJECT});
        end
        n_vec++; if (LATENCY !== '0) begin n_err++; $display("FAIL reset_latency got=%0d exp=0", LATENCY); end
        RESET = 1'b0;
        exp_d = 8'h00;
        exp_lat = '0;
    endtask

    task automatic test_load;
        logic [7:0] code;
        for (int k = 0; k < 4; k++) begin
            code = (k == 0) ? 8'hA5 : 8'($urandom);
            run_seq(1'b1, 1'b0, code, -1, -1, 1'b0, 1'b0);
            exp_d = code;
            n_vec++; if (hang != 0) begin n_err++; $display("FAIL load_hang got=%0d exp=0", hang); end
            n_vec++; if (d_first !== code) begin n_err++; $display("FAIL load_d_out got=%h exp=%h", d_first, code); end
            n_vec++; if (le_n != LE_C) begin n_err++; $display("FAIL load_le_width got=%0d exp=%0d", le_n, LE_C); end
            n_vec++; if (le_first != 1) begin n_err++; $display("FAIL load_le_start got=%0d exp=1", le_first); end
            n_vec++; if (busy_n != LE_C + 1) begin n_err++; $display("FAIL load_busy got=%0d exp=%0d", busy_n, LE_C + 1); end
            n_vec++;
            if (rej_n != 0 || trig_n != 0) begin
                n_err++; $display("FAIL load_extra got rej=%0d trig=%0d exp=0,0", rej_n, trig_n);
            end
            n_vec++; if (D_OUT !== exp_d) begin n_err++; $display("FAIL load_d_hold got=%h exp=%h", D_OUT, exp_d); end
        end
    endtask

    task automatic test_fire;
        int d, exp_done;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: d = 5;
                1: d = -2;
                2: d = -1;
                3: d = 61;
                default: d = int'($urandom_range(60, 0));
            endcase
            run_seq(1'b0, 1'b1, exp_d, SETUP_C + d, -1, 1'b0, 1'b0);
            exp_done = SETUP_C + ((d + 2 > TRIG_C) ? d + 2 : TRIG_C) + 1;
`ifdef AD9500_CTRL_MEAS_EN
            exp_lat = CW'(d + 2);
`endif
            n_vec++; if (hang != 0) begin n_err++; $display("FAIL fire_hang d=%0d got=%0d exp=0", d, hang); end
            n_vec++; if (trig_first != SETUP_C) begin n_err++; $display("FAIL fire_setup d=%0d got=%0d exp=%0d", d, trig_first, SETUP_C); end
            n_vec++; if (trig_n != TRIG_C) begin n_err++; $display("FAIL fire_trig_width d=%0d got=%0d exp=%0d", d, trig_n, TRIG_C); end
            n_vec++; if (done_n != 1) begin n_err++; $display("FAIL fire_done_count d=%0d got=%0d exp=1", d, done_n); end
            n_vec++; if (done_i != exp_done) begin n_err++; $display("FAIL fire_done_time d=%0d got=%0d exp=%0d", d, done_i, exp_done); end
            n_vec++; if (tmo_n != 0) begin n_err++; $display("FAIL fire_timeout d=%0d got=%0d exp=0", d, tmo_n); end
            n_vec++; if (rst_n != RST_C) begin n_err++; $display("FAIL fire_rst_width d=%0d got=%0d exp=%0d", d, rst_n, RST_C); end
            n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL fire_latency d=%0d got=%0d exp=%0d", d, LATENCY, exp_lat); end
            n_vec++; if (d_bad) begin n_err++; $display("FAIL fire_d_stable d=%0d got=changed exp=%h", d, exp_d); end
        end
    endtask

    task automatic test_timeout;
        run_seq(1'b0, 1'b1, exp_d, -1, -1, 1'b0, 1'b0);
        n_vec++; if (hang != 0) begin n_err++; $display("FAIL tmo_hang got=%0d exp=0", hang); end
        n_vec++; if (done_n != 0) begin n_err++; $display("FAIL tmo_done got=%0d exp=0", done_n); end
        n_vec++; if (tmo_n != 1) begin n_err++; $display("FAIL tmo_count got=%0d exp=1", tmo_n); end
        n_vec++; if (tmo_i != SETUP_C + TMO_C + 1) begin n_err++; $display("FAIL tmo_time got=%0d exp=%0d", tmo_i, SETUP_C + TMO_C + 1); end
        n_vec++; if (rst_n != RST_C) begin n_err++; $display("FAIL tmo_rst_width got=%0d exp=%0d", rst_n, RST_C); end
        n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL tmo_latency got=%0d exp=%0d", LATENCY, exp_lat); end
    endtask

    task automatic test_load_fire;
        logic [7:0] code;
        int d, t0;
        t0 = LE_C + 1 + SETUP_C;
        for (int k = 0; k < 3; k++) begin
            code = (k == 0) ? 8'h10 : 8'($urandom);
            d = int'($urandom_range(20, 0));
            run_seq(1'b1, 1'b1, code, t0 + d, -1, 1'b0, 1'b0);
            exp_d = code;
`ifdef AD9500_CTRL_MEAS_EN
            exp_lat = CW'(d + 2);
`endif
            n_vec++; if (hang != 0) begin n_err++; $display("FAIL lf_hang got=%0d exp=0", hang); end
            n_vec++; if (le_n != LE_C || le_first != 1) begin n_err++; $display("FAIL lf_le got=%0d@%0d exp=%0d@1", le_n, le_first, LE_C); end
            n_vec++; if (trig_first != t0) begin n_err++; $display("FAIL lf_trig_start got=%0d exp=%0d", trig_first, t0); end
            n_vec++; if (d_bad) begin n_err++; $display("FAIL lf_d_during_trig got=changed exp=%h", code); end
            n_vec++; if (done_n != 1) begin n_err++; $display("FAIL lf_done got=%0d exp=1", done_n); end
            n_vec++; if (rej_n != 0) begin n_err++; $display("FAIL lf_reject got=%0d exp=0", rej_n); end
            n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL lf_latency got=%0d exp=%0d", LATENCY, exp_lat); end
        end
    endtask

    task automatic test_back_to_back;
        int d, inj, exp_done;
        logic ld;
        for (int k = 0; k < 3; k++) begin
            d = 20;
            inj = SETUP_C + TRIG_C + int'($urandom_range(10, 1));
            ld = (k == 1);
            run_seq(1'b0, 1'b1, exp_d, SETUP_C + d, inj, ld, 1'b0);
            exp_done = SETUP_C + d + 2 + 1;
`ifdef AD9500_CTRL_MEAS_EN
            exp_lat = CW'(d + 2);
`endif
            n_vec++; if (rej_n != 1 || rej_i != inj + 1) begin n_err++; $display("FAIL busy_reject got=%0d@%0d exp=1@%0d", rej_n, rej_i, inj + 1); end
            n_vec++; if (done_n != 1 || done_i != exp_done) begin n_err++; $display("FAIL busy_done got=%0d@%0d exp=1@%0d", done_n, done_i, exp_done); end
            n_vec++; if (D_OUT !== exp_d) begin n_err++; $display("FAIL busy_d_out got=%h exp=%h", D_OUT, exp_d); end
            n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL busy_latency got=%0d exp=%0d", LATENCY, exp_lat); end
        end
    endtask

    task automatic test_reject_stuck;
        Q_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        run_seq(1'b0, 1'b1, exp_d, -1, -1, 1'b0, 1'b1);
        Q_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++; if (hang != 0) begin n_err++; $display("FAIL stuck_hang got=%0d exp=0", hang); end
        n_vec++; if (rej_n != 1 || rej_i != 0) begin n_err++; $display("FAIL stuck_reject got=%0d@%0d exp=1@0", rej_n, rej_i); end
        n_vec++; if (trig_n != 0 || done_n != 0) begin n_err++; $display("FAIL stuck_trig got trig=%0d done=%0d exp=0,0", trig_n, done_n); end
        n_vec++; if (rst_n != RST_C) begin n_err++; $display("FAIL stuck_rst_width got=%0d exp=%0d", rst_n, RST_C); end
        n_vec++; if (tmo_n != 1 || tmo_i != RST_C + TMO_C) begin n_err++; $display("FAIL stuck_timeout got=%0d@%0d exp=1@%0d", tmo_n, tmo_i, RST_C + TMO_C); end
        n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL stuck_latency got=%0d exp=%0d", LATENCY, exp_lat); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int bad = 0;
        DELAY_IN = exp_d; FIRE = 1'b1;
        @(posedge CLK); #1;
        FIRE = 1'b0; Q_IN = 1'b1;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge CLK); #1;
            if (TRIG_OUT) seen = 1;
        end
        n_vec++; if (seen != 1) begin n_err++; $display("FAIL rmid_trig_seen got=%0d exp=1", seen); end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; Q_IN = 1'b0;
        exp_d = 8'h00; exp_lat = '0;
        n_vec++; if (TRIG_OUT !== 1'b0 || BUSY !== 1'b0) begin n_err++; $display("FAIL rmid_abort got trig=%b busy=%b exp=0,0", TRIG_OUT, BUSY); end
        n_vec++; if (D_OUT !== 8'h00) begin n_err++; $display("FAIL rmid_d_out got=%h exp=00", D_OUT); end
        n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL rmid_latency got=%0d exp=0", LATENCY); end
        for (int i = 0; i < 6; i++) begin
            if (DONE || TIMEOUT || BUSY) bad++;
            @(posedge CLK); #1;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rmid_quiet got=%0d exp=0", bad); end
        run_seq(1'b0, 1'b1, exp_d, SETUP_C + 4, -1, 1'b0, 1'b0);
`ifdef AD9500_CTRL_MEAS_EN
        exp_lat = CW'(6);
`endif
        n_vec++; if (done_n != 1 || tmo_n != 0) begin n_err++; $display("FAIL rmid_refire got done=%0d tmo=%0d exp=1,0", done_n, tmo_n); end
        n_vec++; if (LATENCY !== exp_lat) begin n_err++; $display("FAIL rmid_refire_latency got=%0d exp=%0d", LATENCY, exp_lat); end
    endtask

    initial begin
        RESET = 1'b1; LOAD = 1'b0; FIRE = 1'b0; Q_IN = 1'b0; DELAY_IN = 8'h00;
        exp_d = 8'h00; exp_lat = '0;
        test_reset;
        test_load;
        test_fire;
        test_timeout;
        test_load_fire;
        test_back_to_back;
        test_reject_stuck;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
